// File: rtl/panda_prefetch_if.sv
// Instruction prefetch unit: credit-limited request stream, response FIFO, IF/ID output register.
// Optional misaligned-redirect checking under PANDA_FETCH_MISALIGN_CHK_EN; if_id_o = {instr, pc, pc_inc, valid}.
module panda_prefetch_if #(
  parameter int unsigned Depth    = 4,
  parameter logic [31:0] BootAddr = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        change_flow_i,
  input  logic [31:0] jb_address_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic [96:0] if_id_o,
  output logic        fetch_fault_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CntW   = PtrW + 1;
  localparam logic [CntW:0] Limit  = (CntW + 1)'(Depth);
  localparam logic [96:0]   Bubble = {32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b0};

  logic [31:0]     fetch_pc_r, fetch_pc_nxt_s;
  logic [31:0]     resp_pc_r, resp_pc_nxt_s;
  logic [CntW-1:0] out_r, out_nxt_s;
  logic [CntW-1:0] discard_r, discard_nxt_s;
  logic [CntW-1:0] count_r, count_nxt_s;
  logic [PtrW-1:0] wr_ptr_r, wr_ptr_nxt_s;
  logic [PtrW-1:0] rd_ptr_r, rd_ptr_nxt_s;
  logic [63:0]     mem_r [Depth];
  logic [63:0]     head_s;
  logic [96:0]     if_id_r, if_id_nxt_s;
  logic [31:0]     target_s;
  logic [CntW:0]   credit_s;
  logic            halted_s;
  logic            grant_s;
  logic            drop_s;
  logic            push_s;
  logic            pop_s;

`ifdef PANDA_FETCH_MISALIGN_CHK_EN
  logic misalign_s;
  logic halted_r;
  logic fault_r;

  assign target_s      = jb_address_i;
  assign misalign_s    = change_flow_i & (jb_address_i[1:0] != 2'b00);
  assign halted_s      = halted_r;
  assign fetch_fault_o = fault_r;

  // One-cycle fault pulse; requests stay halted until an aligned redirect
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      halted_r <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      fault_r <= misalign_s;
      if (change_flow_i) begin
        halted_r <= misalign_s;
      end
    end
  end
`else
  logic unused_low_s;

  assign target_s      = {jb_address_i[31:2], 2'b00};
  assign halted_s      = 1'b0;
  assign fetch_fault_o = 1'b0;
  assign unused_low_s  = ^jb_address_i[1:0];
`endif

  // Buffered plus in-flight words never exceed the FIFO depth, so pushes cannot overflow
  assign credit_s     = {1'b0, count_r} + {1'b0, out_r};
  assign instr_req_o  = ~rst_i & ~halted_s & (credit_s < Limit);
  assign instr_addr_o = fetch_pc_r;
  assign head_s       = mem_r[rd_ptr_r];
  assign if_id_o      = if_id_r;

  // Next-state for fetch/response PCs, counters, FIFO pointers and IF/ID register
  always_comb begin
    grant_s        = instr_req_o & instr_gnt_i;
    drop_s         = instr_rvalid_i & (discard_r != {CntW{1'b0}});
    push_s         = instr_rvalid_i & ~drop_s & ~change_flow_i;
    pop_s          = ~stall_i & ~flush_i & (count_r != {CntW{1'b0}});
    out_nxt_s      = out_r + CntW'(grant_s) - CntW'(instr_rvalid_i);
    fetch_pc_nxt_s = fetch_pc_r;
    resp_pc_nxt_s  = resp_pc_r;
    discard_nxt_s  = discard_r;
    count_nxt_s    = count_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    if_id_nxt_s    = if_id_r;

    if (change_flow_i) begin
      // Everything still in flight, including this cycle's grant, belongs to the old path
      fetch_pc_nxt_s = target_s;
      resp_pc_nxt_s  = target_s;
      discard_nxt_s  = out_nxt_s;
      count_nxt_s    = {CntW{1'b0}};
      wr_ptr_nxt_s   = {PtrW{1'b0}};
      rd_ptr_nxt_s   = {PtrW{1'b0}};
    end else begin
      if (grant_s) begin
        fetch_pc_nxt_s = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      if (push_s) begin
        resp_pc_nxt_s = resp_pc_r + 32'd4;
        wr_ptr_nxt_s  = wr_ptr_r + PtrW'(1'b1);
      end else begin
        resp_pc_nxt_s = resp_pc_r;
        wr_ptr_nxt_s  = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PtrW'(1'b1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (drop_s) begin
        discard_nxt_s = discard_r - CntW'(1'b1);
      end else begin
        discard_nxt_s = discard_r;
      end
      count_nxt_s = count_r + CntW'(push_s) - CntW'(pop_s);
    end

    if (stall_i) begin
      if_id_nxt_s = if_id_r;
    end else if (flush_i) begin
      if_id_nxt_s = Bubble;
    end else if (count_r != {CntW{1'b0}}) begin
      if_id_nxt_s = {head_s[31:0], head_s[63:32], head_s[63:32] + 32'd4, 1'b1};
    end else begin
      if_id_nxt_s = Bubble;
    end
  end

  // Control state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_r <= BootAddr;
      resp_pc_r  <= BootAddr;
      out_r      <= {CntW{1'b0}};
      discard_r  <= {CntW{1'b0}};
      count_r    <= {CntW{1'b0}};
      wr_ptr_r   <= {PtrW{1'b0}};
      rd_ptr_r   <= {PtrW{1'b0}};
      if_id_r    <= Bubble;
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      resp_pc_r  <= resp_pc_nxt_s;
      out_r      <= out_nxt_s;
      discard_r  <= discard_nxt_s;
      count_r    <= count_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      if_id_r    <= if_id_nxt_s;
    end
  end

  // FIFO storage; entries are only read while counted as occupied, so no reset needed
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {resp_pc_r, instr_rdata_i};
    end
  end

endmodule
